// File: rtl/ftq_ckpt_pkg.sv
// Shared types and sizing helpers for the fetch target queue.
// The per-entry struct depends on module parameters, so it is declared in ftq_ckpt.
package ftq_ckpt_pkg;

    localparam int unsigned DEFAULT_INSTR_PER_FETCH = 4;

    // Default resolution packet; the queue only looks at .valid.
    typedef struct packed {
        logic valid;
        logic taken;
    } bht_update_default_t;

    // Head/tail pointers carry one extra wrap bit above the entry index.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Branch count per entry must hold 1..INSTR_PER_FETCH inclusive.
    function automatic int unsigned cnt_width(input int unsigned instr_per_fetch);
        return $clog2(instr_per_fetch) + 1;
    endfunction

endpackage

// File: rtl/ftq_ckpt_popcount.sv
// Population count of a small bit vector; used for the surviving-branch count.
module ftq_ckpt_popcount #(
    parameter int unsigned INPUT_WIDTH = 4,
    localparam int unsigned OUT_W = $clog2(INPUT_WIDTH) + 1
) (
    input  logic [INPUT_WIDTH-1:0] data_i,
    output logic [OUT_W-1:0]       popcount_o
);

    always_comb begin
        popcount_o = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            popcount_o = popcount_o + OUT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/ftq_ckpt.sv
// Fetch target queue: stores predictor metadata per fetch block with surviving
// conditional branches and hands it back in order, one resolved branch at a time.
module ftq_ckpt
    import ftq_ckpt_pkg::*;
#(
    parameter int unsigned INSTR_PER_FETCH = DEFAULT_INSTR_PER_FETCH,
    parameter int unsigned VLEN            = 32,
    parameter type         bp_metadata_t   = logic,
    parameter type         bht_update_t    = bht_update_default_t,
    parameter int unsigned FTQ_DEPTH       = 8,
    localparam int unsigned IDX_W    = $clog2(FTQ_DEPTH),
    localparam int unsigned PTR_W    = ptr_width(FTQ_DEPTH),
    localparam int unsigned LOG2_IPF = $clog2(INSTR_PER_FETCH),
    localparam int unsigned CNT_W    = cnt_width(INSTR_PER_FETCH)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       squash_i,
    input  logic [IDX_W-1:0]           squash_idx_i,
    input  logic                       debug_mode_i,
    input  logic [INSTR_PER_FETCH-1:0] valid_i,
    input  logic [INSTR_PER_FETCH-1:0] is_branch_i,
    input  logic [INSTR_PER_FETCH-1:0] taken_cf_i,
    input  logic                       replay_i,
    input  logic [VLEN-1:0]            replay_addr_i,
    input  logic                       serving_unaligned_i,
    input  bp_metadata_t               bp_metadata_i,
    input  bht_update_t                bht_update_i,
    output bp_metadata_t               bp_metadata_o,
    output logic                       head_valid_o,
    output logic [IDX_W-1:0]           push_idx_o,
    output logic [PTR_W-1:0]           usage_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    typedef struct packed {
        bp_metadata_t     meta;
        logic [CNT_W-1:0] cnt;
    } ftq_entry_t;

    ftq_entry_t           mem_reg [FTQ_DEPTH];
    logic [PTR_W-1:0]     head_reg, head_next;
    logic [PTR_W-1:0]     tail_reg, tail_next;
    logic [CNT_W-1:0]     consumed_reg, consumed_next;

    logic [LOG2_IPF-1:0]        replay_pos;
    logic [INSTR_PER_FETCH-1:0] replay_mask;
    logic [INSTR_PER_FETCH-1:0] taken_vec;
    logic [INSTR_PER_FETCH-1:0] survivors;
    logic [CNT_W-1:0]           survivor_cnt;

    logic             empty, full;
    logic             push_req, push, update_valid, consume, pop;
    ftq_entry_t       head_entry, new_entry;
    logic [IDX_W-1:0] squash_dist;
    logic [PTR_W-1:0] squash_tail;
    logic             squash_live;

    // Slots at or beyond the replay point are re-fetched later, so they never count here.
    assign replay_pos  = serving_unaligned_i ? '0 : replay_addr_i[LOG2_IPF:1];
    assign replay_mask = {INSTR_PER_FETCH{replay_i}} << replay_pos;
    assign taken_vec   = valid_i & taken_cf_i;

    for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_slot
        if (gi == 0) begin : g_first
            assign survivors[gi] = is_branch_i[gi] & ~replay_mask[gi];
        end else begin : g_rest
            assign survivors[gi] = is_branch_i[gi] & ~replay_mask[gi] & ~|taken_vec[gi-1:0];
        end
    end

    ftq_ckpt_popcount #(
        .INPUT_WIDTH (INSTR_PER_FETCH)
    ) i_popcount (
        .data_i     (survivors),
        .popcount_o (survivor_cnt)
    );

    assign empty      = (head_reg == tail_reg);
    assign full       = (head_reg[IDX_W-1:0] == tail_reg[IDX_W-1:0]) &&
                        (head_reg[IDX_W] != tail_reg[IDX_W]);
    assign head_entry = mem_reg[head_reg[IDX_W-1:0]];
    assign new_entry  = '{meta: bp_metadata_i, cnt: survivor_cnt};

    assign push_req     = |survivors;
    assign push         = push_req & ~full & ~squash_i & ~flush_i;
    assign update_valid = bht_update_i.valid & ~debug_mode_i;
    assign consume      = update_valid & ~empty & ~flush_i;
    assign pop          = consume & ((consumed_reg + CNT_W'(1)) == head_entry.cnt);

    // Tail lands right after the kept entry; building it from head keeps the wrap bit right.
    assign squash_dist = squash_idx_i - head_reg[IDX_W-1:0];
    assign squash_tail = head_reg + PTR_W'(squash_dist) + PTR_W'(1);
    assign squash_live = (PTR_W'(squash_dist) < usage_o);

    always_comb begin
        head_next     = head_reg + PTR_W'(pop);
        tail_next     = tail_reg;
        consumed_next = consumed_reg;
        if (squash_i) begin
            tail_next = squash_tail;
        end else if (push) begin
            tail_next = tail_reg + PTR_W'(1);
        end
        if (pop) begin
            consumed_next = '0;
        end else if (consume) begin
            consumed_next = consumed_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            consumed_reg <= '0;
            mem_reg      <= '{default: '0};
        end else if (flush_i) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            consumed_reg <= '0;
            mem_reg      <= '{default: '0};
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            consumed_reg <= consumed_next;
            if (push) begin
                mem_reg[tail_reg[IDX_W-1:0]] <= new_entry;
            end
        end
    end

    assign head_valid_o  = ~empty;
    assign bp_metadata_o = empty ? '0 : head_entry.meta;
    assign push_idx_o    = tail_reg[IDX_W-1:0];
    assign usage_o       = tail_reg - head_reg;
    assign overflow_o    = push_req & full & ~squash_i & ~flush_i;
    assign underflow_o   = update_valid & empty & ~flush_i;

    logic unused_bits;
    assign unused_bits = ^{replay_addr_i[VLEN-1:LOG2_IPF+1], replay_addr_i[0],
                           taken_vec[INSTR_PER_FETCH-1], bht_update_i};

    // A squash must name an entry that is still in the queue.
    a_squash_live: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (squash_i && !flush_i) |-> squash_live);

endmodule
